// File: rtl/mtn_sched_pkg.sv
// Shared types and helpers for the maintenance task scheduler: state encoding,
// default channel/location widths and the channel-index width function.
package mtn_sched_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_ISSUE = ISSUE,
    ST_WAIT  = WAIT
  } state_t;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_LCN_W = 8;

  // Index width for n channels; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or
// after the pointer (wrapping), plus an any-request flag.
module rr_arbiter
  import mtn_sched_pkg::*;
#(
  parameter int N  = DEF_N_CH,
  parameter int PW = ch_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          any_req
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mtn_task_scheduler.sv
// Queues per-channel maintenance requests and issues them one at a time to the robot.
// Optional watchdog abort is compiled in when SCHED_TIMEOUT_EN is defined.
module mtn_task_scheduler
  import mtn_sched_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int LCN_W       = DEF_LCN_W,
  parameter int OVF_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic [N_CH-1:0]          MTN_SENSOR,
  input  logic [LCN_W-1:0]         LOCATION,
  input  logic                     TASK_RDY,
  input  logic                     TASK_DONE,
  output logic                     TASK_VLD,
  output logic [ch_w(N_CH)-1:0]    TASK_TYPE,
  output logic [LCN_W-1:0]         TASK_LCN,
  output logic                     BUSY,
  output logic [N_CH-1:0]          PEND,
  output logic [OVF_W-1:0]         OVF_CNT,
  output logic                     ABORT
);

  localparam int CW = ch_w(N_CH);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must fit the 16-bit watchdog counter");
  end

  state_t            state_reg, state_next;
  logic [N_CH-1:0]   hist_reg;
  logic [N_CH-1:0]   rise;
  logic [N_CH-1:0]   pend_reg, pend_next;
  logic [LCN_W-1:0]  lcn_reg  [N_CH];
  logic [LCN_W-1:0]  lcn_next [N_CH];
  logic [CW-1:0]     rr_ptr_reg;
  logic              task_vld_reg;
  logic [CW-1:0]     task_type_reg;
  logic [LCN_W-1:0]  task_lcn_reg;
  logic [OVF_W-1:0]  ovf_reg, ovf_next;

  logic [N_CH-1:0]   grant_oh;
  logic              any_req;
  logic [CW-1:0]     grant_idx;
  logic              do_grant;
  logic              wd_fire;
  logic [N_CH-1:0]   clr, requeue, take, ovf_hit;

  assign rise = MTN_SENSOR & ~hist_reg;

  rr_arbiter #(.N(N_CH), .PW(CW)) u_arb (
    .req     (pend_reg),
    .ptr     (rr_ptr_reg),
    .grant   (grant_oh),
    .any_req (any_req)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_oh[i]) grant_idx = CW'(i);
    end
  end

  assign do_grant = EN && (state_reg == ST_IDLE) && any_req;

  // A rise on a channel being granted this cycle re-pends it rather than overflowing.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign clr[gi]       = do_grant & grant_oh[gi];
    assign requeue[gi]   = wd_fire & (task_type_reg == CW'(gi)) & ~pend_reg[gi];
    assign take[gi]      = rise[gi] & (~pend_reg[gi] | clr[gi]);
    assign ovf_hit[gi]   = rise[gi] & pend_reg[gi] & ~clr[gi];
    assign pend_next[gi] = rise[gi] | requeue[gi] | (pend_reg[gi] & ~clr[gi]);
    assign lcn_next[gi]  = take[gi]    ? LOCATION :
                           requeue[gi] ? task_lcn_reg : lcn_reg[gi];
  end

  always_comb begin
    ovf_next = ovf_reg;
    for (int i = 0; i < N_CH; i++) begin
      if (ovf_hit[i] && (ovf_next != {OVF_W{1'b1}})) ovf_next = ovf_next + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (do_grant)  state_next = ST_ISSUE;
      ST_ISSUE: if (TASK_RDY)  state_next = ST_WAIT;
      ST_WAIT:  if (TASK_DONE) state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
    if (wd_fire || !EN) state_next = ST_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // History tracks the sensors even while disabled so held levels never re-trigger.
  always_ff @(posedge CLK) begin
    if (RST) hist_reg <= '0;
    else     hist_reg <= MTN_SENSOR;
  end

  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      pend_reg <= '0;
      for (int i = 0; i < N_CH; i++) lcn_reg[i] <= '0;
    end else begin
      pend_reg <= pend_next;
      lcn_reg  <= lcn_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)     ovf_reg <= '0;
    else if (EN) ovf_reg <= ovf_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      task_vld_reg  <= 1'b0;
      task_type_reg <= '0;
      task_lcn_reg  <= '0;
      rr_ptr_reg    <= '0;
    end else if (!EN || wd_fire) begin
      task_vld_reg <= 1'b0;
    end else if (do_grant) begin
      task_vld_reg  <= 1'b1;
      task_type_reg <= grant_idx;
      task_lcn_reg  <= lcn_reg[grant_idx];
      rr_ptr_reg    <= (grant_idx == CW'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
    end else if (state_reg == ST_ISSUE && TASK_RDY) begin
      task_vld_reg <= 1'b0;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  logic [15:0] wd_cnt_reg;
  logic        abort_reg;

  assign wd_fire = EN && (state_reg != ST_IDLE) && (wd_cnt_reg == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_cnt_reg <= '0;
      abort_reg  <= 1'b0;
    end else begin
      abort_reg <= wd_fire;
      if (state_reg == ST_IDLE || state_next != state_reg) wd_cnt_reg <= '0;
      else                                                  wd_cnt_reg <= wd_cnt_reg + 16'd1;
    end
  end

  assign ABORT = abort_reg;
`else
  assign wd_fire = 1'b0;
  assign ABORT   = 1'b0;
`endif

  assign TASK_VLD  = task_vld_reg;
  assign TASK_TYPE = task_type_reg;
  assign TASK_LCN  = task_lcn_reg;
  assign BUSY      = (state_reg != ST_IDLE);
  assign PEND      = pend_reg;
  assign OVF_CNT   = ovf_reg;

endmodule

// File: tb/tb_mtn_task_scheduler.sv
// Directed bench for mtn_task_scheduler: a cycle table for the basic flow plus
// hand-written sequences for overflow, stall, disable, reset and watchdog corners.
module tb_mtn_task_scheduler;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic [3:0] MTN_SENSOR = '0;
  logic [7:0] LOCATION = '0;
  logic       TASK_RDY = 1'b0;
  logic       TASK_DONE = 1'b0;
  logic       TASK_VLD;
  logic [1:0] TASK_TYPE;
  logic [7:0] TASK_LCN;
  logic       BUSY;
  logic [3:0] PEND;
  logic [7:0] OVF_CNT;
  logic       ABORT;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mtn_task_scheduler dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MTN_SENSOR(MTN_SENSOR), .LOCATION(LOCATION),
    .TASK_RDY(TASK_RDY), .TASK_DONE(TASK_DONE), .TASK_VLD(TASK_VLD),
    .TASK_TYPE(TASK_TYPE), .TASK_LCN(TASK_LCN), .BUSY(BUSY), .PEND(PEND),
    .OVF_CNT(OVF_CNT), .ABORT(ABORT)
  );

  typedef struct {
    logic       en;
    logic [3:0] sens;
    logic [7:0] loc;
    logic       rdy;
    logic       done;
    logic       vld;
    logic [1:0] typ;
    logic [7:0] lcn;
    logic       busy;
    logic [3:0] pend;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic en, input logic [3:0] s, input logic [7:0] l,
                              input logic r, input logic d, input logic v, input logic [1:0] t,
                              input logic [7:0] c, input logic b, input logic [3:0] p);
    vec_t x;
    x.en = en; x.sens = s; x.loc = l; x.rdy = r; x.done = d;
    x.vld = v; x.typ = t; x.lcn = c; x.busy = b; x.pend = p;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic en, input logic [3:0] s, input logic [7:0] l,
                     input logic r, input logic d);
    EN = en; MTN_SENSOR = s; LOCATION = l; TASK_RDY = r; TASK_DONE = d;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drv(1'b0, 4'b0000, 8'h00, 1'b0, 1'b0);
    drv(1'b0, 4'b0000, 8'h00, 1'b0, 1'b0);
    RST = 1'b0;
  endtask

  initial begin
    // Flow table: requests, round-robin order, accept/done handshakes.
    vq.push_back(mk(1, 4'b0000, 8'h00, 0, 0, 0, 2'd0, 8'h00, 0, 4'b0000));
    vq.push_back(mk(1, 4'b0001, 8'h20, 0, 0, 0, 2'd0, 8'h00, 0, 4'b0001));
    vq.push_back(mk(1, 4'b0001, 8'h33, 0, 0, 1, 2'd0, 8'h20, 1, 4'b0000));
    vq.push_back(mk(1, 4'b0001, 8'h33, 1, 0, 0, 2'd0, 8'h20, 1, 4'b0000));
    vq.push_back(mk(1, 4'b0001, 8'h33, 0, 1, 0, 2'd0, 8'h20, 0, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 8'h33, 0, 0, 0, 2'd0, 8'h20, 0, 4'b0000));
    vq.push_back(mk(1, 4'b1010, 8'h44, 1, 0, 0, 2'd0, 8'h20, 0, 4'b1010));
    vq.push_back(mk(1, 4'b1010, 8'h55, 1, 0, 1, 2'd1, 8'h44, 1, 4'b1000));
    vq.push_back(mk(1, 4'b1010, 8'h55, 1, 0, 0, 2'd1, 8'h44, 1, 4'b1000));
    vq.push_back(mk(1, 4'b1010, 8'h55, 1, 0, 0, 2'd1, 8'h44, 1, 4'b1000));
    vq.push_back(mk(1, 4'b1010, 8'h55, 1, 0, 0, 2'd1, 8'h44, 1, 4'b1000));
    vq.push_back(mk(1, 4'b1010, 8'h55, 1, 1, 0, 2'd1, 8'h44, 0, 4'b1000));
    vq.push_back(mk(1, 4'b1010, 8'h55, 1, 0, 1, 2'd3, 8'h44, 1, 4'b0000));
    vq.push_back(mk(1, 4'b1010, 8'h55, 1, 0, 0, 2'd3, 8'h44, 1, 4'b0000));
    vq.push_back(mk(1, 4'b1010, 8'h55, 1, 0, 0, 2'd3, 8'h44, 1, 4'b0000));
    vq.push_back(mk(1, 4'b1010, 8'h55, 1, 0, 0, 2'd3, 8'h44, 1, 4'b0000));
    vq.push_back(mk(1, 4'b1010, 8'h55, 1, 1, 0, 2'd3, 8'h44, 0, 4'b0000));
    vq.push_back(mk(1, 4'b0101, 8'h66, 0, 0, 0, 2'd3, 8'h44, 0, 4'b0101));
    vq.push_back(mk(1, 4'b0101, 8'h77, 1, 0, 1, 2'd0, 8'h66, 1, 4'b0100));
    vq.push_back(mk(1, 4'b0101, 8'h77, 1, 0, 0, 2'd0, 8'h66, 1, 4'b0100));
    vq.push_back(mk(1, 4'b0101, 8'h77, 0, 1, 0, 2'd0, 8'h66, 0, 4'b0100));
    vq.push_back(mk(1, 4'b0101, 8'h77, 1, 0, 1, 2'd2, 8'h66, 1, 4'b0000));
    vq.push_back(mk(1, 4'b0101, 8'h77, 1, 0, 0, 2'd2, 8'h66, 1, 4'b0000));
    vq.push_back(mk(1, 4'b0101, 8'h77, 0, 1, 0, 2'd2, 8'h66, 0, 4'b0000));
    vq.push_back(mk(1, 4'b0000, 8'h77, 0, 0, 0, 2'd2, 8'h66, 0, 4'b0000));

    do_reset();
    chk("rst_vld", 32'(TASK_VLD), 32'd0);
    chk("rst_type", 32'(TASK_TYPE), 32'd0);
    chk("rst_lcn", 32'(TASK_LCN), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_pend", 32'(PEND), 32'd0);
    chk("rst_ovf", 32'(OVF_CNT), 32'd0);
    chk("rst_abort", 32'(ABORT), 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      drv(vq[i].en, vq[i].sens, vq[i].loc, vq[i].rdy, vq[i].done);
      $display("vec %0d: sens=%b loc=%h rdy=%b done=%b -> vld=%b type=%0d lcn=%h busy=%b pend=%b",
               i, vq[i].sens, vq[i].loc, vq[i].rdy, vq[i].done, TASK_VLD, TASK_TYPE, TASK_LCN, BUSY, PEND);
      chk($sformatf("vec%0d_vld", i), 32'(TASK_VLD), 32'(vq[i].vld));
      chk($sformatf("vec%0d_type", i), 32'(TASK_TYPE), 32'(vq[i].typ));
      chk($sformatf("vec%0d_lcn", i), 32'(TASK_LCN), 32'(vq[i].lcn));
      chk($sformatf("vec%0d_busy", i), 32'(BUSY), 32'(vq[i].busy));
      chk($sformatf("vec%0d_pend", i), 32'(PEND), 32'(vq[i].pend));
      chk($sformatf("vec%0d_ovf", i), 32'(OVF_CNT), 32'd0);
      chk($sformatf("vec%0d_abort", i), 32'(ABORT), 32'd0);
    end

    // Rise on the channel in the very cycle it is granted.
    do_reset();
    drv(1, 4'b1000, 8'h31, 0, 0);
    drv(1, 4'b1000, 8'h31, 0, 0);
    drv(1, 4'b1000, 8'h31, 1, 0);
    drv(1, 4'b1001, 8'h11, 0, 0);
    drv(1, 4'b1000, 8'h12, 0, 0);
    drv(1, 4'b1000, 8'h12, 0, 1);
    drv(1, 4'b1001, 8'h22, 0, 0);
    $display("seq grant-rise: vld=%b type=%0d lcn=%h pend=%b ovf=%0d", TASK_VLD, TASK_TYPE, TASK_LCN, PEND, OVF_CNT);
    chk("gr_vld", 32'(TASK_VLD), 32'd1);
    chk("gr_type", 32'(TASK_TYPE), 32'd0);
    chk("gr_lcn", 32'(TASK_LCN), 32'h11);
    chk("gr_pend", 32'(PEND), 32'b0001);
    chk("gr_ovf", 32'(OVF_CNT), 32'd0);
    drv(1, 4'b1001, 8'h22, 1, 0);
    drv(1, 4'b1001, 8'h22, 0, 1);
    drv(1, 4'b1001, 8'h22, 0, 0);
    chk("gr2_vld", 32'(TASK_VLD), 32'd1);
    chk("gr2_lcn", 32'(TASK_LCN), 32'h22);
    chk("gr2_pend", 32'(PEND), 32'b0000);

    // Overflow on a pending channel, then saturation.
    do_reset();
    drv(1, 4'b0001, 8'h10, 0, 0);
    drv(1, 4'b0001, 8'h10, 0, 0);
    drv(1, 4'b0001, 8'h10, 1, 0);
    drv(1, 4'b0101, 8'hA1, 0, 0);
    drv(1, 4'b0001, 8'hA2, 0, 0);
    drv(1, 4'b0101, 8'hA3, 0, 0);
    chk("ovf_one", 32'(OVF_CNT), 32'd1);
    chk("ovf_pend", 32'(PEND), 32'b0100);
    drv(1, 4'b0101, 8'hA3, 0, 1);
    drv(1, 4'b0101, 8'hA3, 0, 0);
    $display("seq overflow: vld=%b type=%0d lcn=%h ovf=%0d", TASK_VLD, TASK_TYPE, TASK_LCN, OVF_CNT);
    chk("ovf_type", 32'(TASK_TYPE), 32'd2);
    chk("ovf_first_lcn", 32'(TASK_LCN), 32'hA1);
    drv(1, 4'b0101, 8'hA3, 1, 0);
    for (int k = 0; k < 254; k++) begin
      drv(1, 4'b0001, 8'h00, 0, 0);
      drv(1, 4'b0101, 8'h00, 0, 0);
    end
    chk("ovf_fe", 32'(OVF_CNT), 32'hFE);
    drv(1, 4'b0001, 8'h00, 0, 0);
    drv(1, 4'b0101, 8'h00, 0, 0);
    chk("ovf_ff", 32'(OVF_CNT), 32'hFF);
    for (int k = 0; k < 5; k++) begin
      drv(1, 4'b0001, 8'h00, 0, 0);
      drv(1, 4'b0101, 8'h00, 0, 0);
    end
    $display("seq saturate: ovf=%0h", OVF_CNT);
    chk("ovf_sat", 32'(OVF_CNT), 32'hFF);

    // Offer held while the robot stalls; TASK_DONE during ISSUE has no effect.
    do_reset();
    drv(1, 4'b0010, 8'h5A, 0, 0);
    drv(1, 4'b0010, 8'h5B, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drv(1, 4'b0010, 8'(8'h60 + i), 0, (i == 3 || i == 7));
      chk($sformatf("hold%0d_vld", i), 32'(TASK_VLD), 32'd1);
      chk($sformatf("hold%0d_type", i), 32'(TASK_TYPE), 32'd1);
      chk($sformatf("hold%0d_lcn", i), 32'(TASK_LCN), 32'h5A);
    end
    drv(1, 4'b0010, 8'h70, 1, 0);
    $display("seq stall: vld=%b busy=%b", TASK_VLD, BUSY);
    chk("hold_acc_vld", 32'(TASK_VLD), 32'd0);
    chk("hold_acc_busy", 32'(BUSY), 32'd1);
    drv(1, 4'b0010, 8'h70, 0, 1);
    chk("hold_done_busy", 32'(BUSY), 32'd0);

    // Disable while a task is in flight with two channels pending.
    drv(1, 4'b0011, 8'h01, 0, 0);
    drv(1, 4'b0011, 8'h01, 0, 0);
    drv(1, 4'b0011, 8'h01, 1, 0);
    drv(1, 4'b0001, 8'h02, 0, 0);
    drv(1, 4'b1011, 8'h02, 0, 0);
    chk("dis_pend_pre", 32'(PEND), 32'b1010);
    chk("dis_busy_pre", 32'(BUSY), 32'd1);
    drv(1, 4'b1001, 8'h03, 0, 0);
    drv(1, 4'b1011, 8'h03, 0, 0);
    chk("dis_ovf_pre", 32'(OVF_CNT), 32'd1);
    drv(0, 4'b1011, 8'h04, 0, 0);
    $display("seq disable: busy=%b pend=%b vld=%b ovf=%0d", BUSY, PEND, TASK_VLD, OVF_CNT);
    chk("dis_busy", 32'(BUSY), 32'd0);
    chk("dis_pend", 32'(PEND), 32'b0000);
    chk("dis_vld", 32'(TASK_VLD), 32'd0);
    chk("dis_ovf_kept", 32'(OVF_CNT), 32'd1);
    drv(0, 4'b1011, 8'h04, 0, 0);
    drv(1, 4'b1011, 8'h05, 0, 0);
    chk("reen_pend", 32'(PEND), 32'b0000);
    drv(1, 4'b1011, 8'h05, 0, 0);
    chk("reen_pend2", 32'(PEND), 32'b0000);
    chk("reen_busy", 32'(BUSY), 32'd0);
    chk("reen_vld", 32'(TASK_VLD), 32'd0);

    // Reset in the middle of an offered task.
    drv(1, 4'b0100, 8'h0C, 0, 0);
    drv(1, 4'b0100, 8'h0C, 0, 0);
    chk("mid_vld_pre", 32'(TASK_VLD), 32'd1);
    chk("mid_type_pre", 32'(TASK_TYPE), 32'd2);
    RST = 1'b1;
    drv(1, 4'b0000, 8'h00, 0, 0);
    RST = 1'b0;
    $display("seq mid-reset: vld=%b type=%0d busy=%b pend=%b ovf=%0d", TASK_VLD, TASK_TYPE, BUSY, PEND, OVF_CNT);
    chk("mid_vld", 32'(TASK_VLD), 32'd0);
    chk("mid_type", 32'(TASK_TYPE), 32'd0);
    chk("mid_busy", 32'(BUSY), 32'd0);
    chk("mid_ovf", 32'(OVF_CNT), 32'd0);
    drv(1, 4'b0000, 8'h00, 0, 0);
    chk("mid_pend", 32'(PEND), 32'b0000);

`ifdef SCHED_TIMEOUT_EN
    // Watchdog: accepted task never completes.
    begin
      int n;
      do_reset();
      drv(1, 4'b0001, 8'h77, 0, 0);
      drv(1, 4'b0001, 8'h77, 0, 0);
      drv(1, 4'b0001, 8'h77, 1, 0);
      n = 0;
      for (int i = 1; i <= 70; i++) begin
        drv(1, 4'b0001, 8'h77, 0, 0);
        if (ABORT && n == 0) begin
          n = i;
          chk("wd_busy", 32'(BUSY), 32'd0);
          chk("wd_pend", 32'(PEND), 32'b0001);
          break;
        end
      end
      $display("seq watchdog: abort after %0d cycles", n);
      chk("wd_delay", 32'(n), 32'd64);
      drv(1, 4'b0001, 8'h77, 0, 0);
      chk("wd_abort_pulse", 32'(ABORT), 32'd0);
      chk("wd_reissue_vld", 32'(TASK_VLD), 32'd1);
      chk("wd_reissue_lcn", 32'(TASK_LCN), 32'h77);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
